serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/fsm_pkg.sv | 25 ++
 rtl/tx_shift_reg.sv | 52 +++++
 rtl/serial_pattern_tx.sv | 117 +++++++++++
 tb/tb_serial_pattern_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared FSM definitions: state encodings and gap counter sizing for the
// serial transmitter family.
package fsm_pkg;

   localparam int GAP_CW = 4;

   typedef logic [GAP_CW-1:0] gap_cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_GAP   = 3'd2,
      ST_DONE  = 3'd3
   } state_t;

   // The counter counts down to zero, so it is preloaded with one less than the gap.
   function automatic gap_cnt_t gap_load(input int gap);
      if (gap > 0) begin
         return gap_cnt_t'(gap - 1);
      end else begin
         return gap_cnt_t'(1'b0);
      end
   endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Payload shifter: left-aligns the selected len+1 bits so the MSB of the
// frame is always at the top, and counts the bits still to send.
module tx_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     arstn,
   input  logic                     load,
   input  logic                     shift_en,
   input  logic [WIDTH-1:0]         word,
   input  logic [$clog2(WIDTH)-1:0] len,
   output logic                     cur_bit,
   output logic                     last
);
   localparam int LW = $clog2(WIDTH);
   localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH - 1);

   logic [WIDTH-1:0] shreg_r;
   logic [LW-1:0]    cnt_r;
   logic [LW-1:0]    len_c_s;

   // Lengths beyond the word are clamped at capture.
   always_comb begin
      len_c_s = len;
      if (len > LEN_MAX) begin
         len_c_s = LEN_MAX;
      end else begin
         len_c_s = len;
      end
   end

   // Shift register and remaining-bit counter.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         shreg_r <= {WIDTH{1'b0}};
         cnt_r   <= {LW{1'b0}};
      end else if (load) begin
         shreg_r <= word << (LEN_MAX - len_c_s);
         cnt_r   <= len_c_s;
      end else if (shift_en) begin
         shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
         cnt_r   <= cnt_r - LW'(1);
      end else begin
         shreg_r <= shreg_r;
         cnt_r   <= cnt_r;
      end
   end

   assign cur_bit = shreg_r[WIDTH-1];
   assign last    = (cnt_r == {LW{1'b0}});

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: Moore FSM sending len+1 payload bits MSB first,
// then GAP forced-low cycles and a one-cycle done pulse.
module serial_pattern_tx
   import fsm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input  logic                     clk,
   input  logic                     arstn,
   input  logic                     start,
   input  logic [WIDTH-1:0]         word,
   input  logic [$clog2(WIDTH)-1:0] len,
   input  logic                     hold,
   output logic                     data,
   output logic                     valid,
   output logic                     ready,
   output logic                     done
);
   localparam gap_cnt_t GAP_INIT = gap_load(GAP);

   state_t   state_r;
   state_t   state_s;
   gap_cnt_t gap_cnt_r;
   logic     load_s;
   logic     shift_en_s;
   logic     cur_bit_s;
   logic     last_s;

   tx_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .arstn    (arstn),
      .load     (load_s),
      .shift_en (shift_en_s),
      .word     (word),
      .len      (len),
      .cur_bit  (cur_bit_s),
      .last     (last_s)
   );

   // State register.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Gap counter is kept preloaded while shifting so GAP starts from a known value.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         gap_cnt_r <= gap_cnt_t'(1'b0);
      end else if (state_r == ST_SHIFT) begin
         gap_cnt_r <= GAP_INIT;
      end else if (state_r == ST_GAP) begin
         gap_cnt_r <= gap_cnt_r - gap_cnt_t'(1'b1);
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   // Next-state logic and shifter controls.
   always_comb begin
      state_s    = state_r;
      load_s     = 1'b0;
      shift_en_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_SHIFT;
               load_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (hold) begin
               state_s = ST_SHIFT;
            end else if (last_s) begin
               state_s = (GAP == 0) ? ST_DONE : ST_GAP;
            end else begin
               state_s    = ST_SHIFT;
               shift_en_s = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == gap_cnt_t'(1'b0)) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_GAP;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Moore output decode from the registered state.
   always_comb begin
      data  = 1'b0;
      valid = 1'b0;
      ready = 1'b0;
      done  = 1'b0;
      case (state_r)
         ST_IDLE:  ready = 1'b1;
         ST_SHIFT: begin
            data  = cur_bit_s;
            valid = 1'b1;
         end
         ST_GAP:   data = 1'b0;
         ST_DONE:  done = 1'b1;
         default:  ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx; observations are packed
// as {data, valid, ready, done} and sampled on the falling clock edge.
module tb_serial_pattern_tx;

   logic       clk    = 1'b0;
   logic       arstn  = 1'b0;
   logic       start  = 1'b0;
   logic [7:0] word   = 8'h00;
   logic [2:0] len    = 3'd0;
   logic       hold   = 1'b0;
   logic       data, valid, ready, done;

   logic       start0 = 1'b0;
   logic [7:0] word0  = 8'h00;
   logic [2:0] len0   = 3'd0;
   logic       hold0  = 1'b0;
   logic       data0, valid0, ready0, done0;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut (
      .clk(clk), .arstn(arstn), .start(start), .word(word), .len(len),
      .hold(hold), .data(data), .valid(valid), .ready(ready), .done(done)
   );

   serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut_g0 (
      .clk(clk), .arstn(arstn), .start(start0), .word(word0), .len(len0),
      .hold(hold0), .data(data0), .valid(valid0), .ready(ready0), .done(done0)
   );

   // Request a frame; returns at the falling edge of cycle N+1 with start low.
   task automatic kick(input logic [7:0] w, input logic [2:0] l);
      @(negedge clk);
      word  = w;
      len   = l;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Expected per-cycle observations from N+1 for a GAP=2 frame, ending in IDLE.
   task automatic build_frame(input logic [7:0] w, input logic [2:0] l);
      exp_q.delete();
      for (int i = int'(l); i >= 0; i--) exp_q.push_back({w[i], 3'b100});
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
   endtask

   task automatic test_reset();
      arstn = 1'b0;
      #3;
      checks++;
      if ({data, valid, ready, done} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", {data, valid, ready, done}, 4'b0010);
      end
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({data, valid, ready, done} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", {data, valid, ready, done}, 4'b0010);
      end
      checks++;
      if ({data0, valid0, ready0, done0} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_gap0 got=%b exp=%b", {data0, valid0, ready0, done0}, 4'b0010);
      end
   endtask

   task automatic test_basic();
      build_frame(8'b1101_0010, 3'd7);
      kick(8'b1101_0010, 3'd7);
      word = 8'h0F;
      len  = 3'd1;
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if ({data, valid, ready, done} !== exp_q[k]) begin
            errors++;
            $display("FAIL basic cycle N+%0d got=%b exp=%b", k + 1, {data, valid, ready, done}, exp_q[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_short();
      logic [7:0] w_list [2];
      logic [2:0] l_list [2];
      w_list = '{8'hFF, 8'h35};
      l_list = '{3'd2, 3'd4};
      for (int f = 0; f < 2; f++) begin
         build_frame(w_list[f], l_list[f]);
         kick(w_list[f], l_list[f]);
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if ({data, valid, ready, done} !== exp_q[k]) begin
               errors++;
               $display("FAIL short%0d cycle N+%0d got=%b exp=%b", f, k + 1, {data, valid, ready, done}, exp_q[k]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_hold();
      build_frame(8'b1101_0010, 3'd7);
      exp_q.insert(4, exp_q[4]);
      exp_q.insert(4, exp_q[4]);
      kick(8'b1101_0010, 3'd7);
      for (int k = 0; k < exp_q.size(); k++) begin
         hold = (k == 4 || k == 5 || k == 10 || k == 11) ? 1'b1 : 1'b0;
         checks++;
         if ({data, valid, ready, done} !== exp_q[k]) begin
            errors++;
            $display("FAIL hold cycle N+%0d got=%b exp=%b", k + 1, {data, valid, ready, done}, exp_q[k]);
         end
         @(negedge clk);
      end
      hold = 1'b0;
   endtask

   task automatic test_ignore_start();
      build_frame(8'hC3, 3'd7);
      kick(8'hC3, 3'd7);
      for (int k = 0; k < exp_q.size(); k++) begin
         start = (k == 2 || k == 10) ? 1'b1 : 1'b0;
         checks++;
         if ({data, valid, ready, done} !== exp_q[k]) begin
            errors++;
            $display("FAIL ignore_start cycle N+%0d got=%b exp=%b", k + 1, {data, valid, ready, done}, exp_q[k]);
         end
         @(negedge clk);
      end
      start = 1'b0;
      build_frame(8'h40, 3'd6);
      kick(8'h40, 3'd6);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if ({data, valid, ready, done} !== exp_q[k]) begin
            errors++;
            $display("FAIL after_ignore cycle N+%0d got=%b exp=%b", k + 1, {data, valid, ready, done}, exp_q[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      build_frame(8'b1101_0010, 3'd7);
      kick(8'b1101_0010, 3'd7);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({data, valid, ready, done} !== exp_q[k]) begin
            errors++;
            $display("FAIL pre_reset cycle N+%0d got=%b exp=%b", k + 1, {data, valid, ready, done}, exp_q[k]);
         end
         if (k < 3) @(negedge clk);
      end
      #1 arstn = 1'b0;
      #1;
      checks++;
      if ({data, valid, ready, done} !== 4'b0010) begin
         errors++;
         $display("FAIL mid_reset_immediate got=%b exp=%b", {data, valid, ready, done}, 4'b0010);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 2) arstn = 1'b1;
         checks++;
         if ({data, valid, ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL mid_reset_hold%0d got=%b exp=%b", k, {data, valid, ready, done}, 4'b0010);
         end
      end
      build_frame(8'hA5, 3'd7);
      kick(8'hA5, 3'd7);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if ({data, valid, ready, done} !== exp_q[k]) begin
            errors++;
            $display("FAIL post_reset cycle N+%0d got=%b exp=%b", k + 1, {data, valid, ready, done}, exp_q[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_gap0();
      logic [3:0] exp0 [3];
      exp0 = '{4'b1100, 4'b0001, 4'b0010};
      @(negedge clk);
      word0  = 8'h01;
      len0   = 3'd0;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({data0, valid0, ready0, done0} !== exp0[k]) begin
            errors++;
            $display("FAIL gap0 cycle N+%0d got=%b exp=%b", k + 1, {data0, valid0, ready0, done0}, exp0[k]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_hold();
      test_ignore_start();
      test_reset_mid();
      test_gap0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
